div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  EX-stage request to divide; held high until ready seen.
REQ-004 signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-005 opdata1  input  32  dividend (rs).
REQ-006 opdata2  input  32  divisor (rt).
REQ-007 annul  input  1  pipeline flush; cancels any in-flight divide.
REQ-008 result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009 ready  output  1  result valid; HI/LO write strobe for the pipeline.
REQ-010 stall_req  output  1  stall request to hazard unit.

Function
REQ-011 States SHALL be IDLE, BYZERO, ON, END.
REQ-012 IDLE: start=1 and annul=0 at an edge SHALL latch signed_div, opdata1 and opdata2, clear the iteration counter, and enter BYZERO if opdata2==0, else ON.
REQ-013 Operand inputs SHALL be ignored after acceptance; later changes have no effect on the running divide.
REQ-014 Signed mode SHALL latch magnitudes: |opdata1|, |opdata2|, with two's-complement negation; 0x80000000 stays 0x80000000 as an unsigned magnitude.
REQ-015 ON SHALL perform one restoring radix-2 step per cycle: shift the partial remainder left and bring in the next dividend bit; trial-subtract the divisor magnitude (33-bit); if non-negative, keep the difference and set the quotient bit to 1, else keep the remainder and set the quotient bit to 0.
REQ-016 A 5-bit counter SHALL increment each ON cycle; the step at count==31 SHALL transition to END (32 steps total).
REQ-017 On entry to END, signed mode SHALL negate the quotient when the operand signs differ and give the remainder the sign of the dividend; unsigned mode applies no correction.
REQ-018 BYZERO SHALL transition to END on the next edge with result = 64'h0.
REQ-019 Latency: start accepted at edge N gives ready=1 after edge N+32 (ON path) or after edge N+1 (BYZERO path).
REQ-020 END SHALL hold ready=1 and result stable while start=1; start=0 at an edge returns to IDLE.
REQ-021 ready SHALL be 0 in every state except END; result SHALL read 64'h0 whenever ready=0.
REQ-022 stall_req SHALL be combinational: start & ~ready.
REQ-023 annul=1 at an edge in BYZERO, ON or END SHALL return the block to IDLE, with no ready pulse and the counter cleared; annul takes priority over all other transitions.
REQ-024 start and annul both high in IDLE SHALL not accept an operation.
REQ-025 A new start SHALL be accepted on the first IDLE edge after END or annul; there are no back-to-back divides without an IDLE cycle.
REQ-026 Quotient overflow (0x80000000 / -1, signed) SHALL wrap: quotient 0x80000000, remainder 0; no exception is raised.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, counter 0, latched operands 0, ready=0 and result=0, regardless of clk.
REQ-028 rst asserted mid-operation SHALL abort the divide with no ready pulse; after release, the block accepts start normally.

Verification
REQ-029 DIVU 100/7, start at edge N -> ready first high after edge N+32, result = {32'd2, 32'd14}; stall_req high in cycles N..N+31.
REQ-030 DIV -7/2 -> result = {0xFFFFFFFF, 0xFFFFFFFD}; DIV 7/-2 -> {0x00000001, 0xFFFFFFFD}.
REQ-031 DIVU 0x1234/0 -> ready after edge N+1, result = 0; DIV 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}; DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
REQ-032 Annul at edge N+10 of a DIVU, then start 9/3 two edges later -> no ready for the first divide; second divide gives {0, 3} at its own N'+32.
REQ-033 Async rst pulse between edges mid-ON -> ready and result 0 immediately; the next divide completes correctly.
REQ-034 Hold start high through END for 3 cycles with operands changing -> ready and result constant; drop start -> IDLE next edge, ready=0.

Source files
------------

// File: rtl/div_if.sv
// Divider request/response bundle between the EX stage and the sequential divider.
interface div_if;
  localparam int unsigned W = 32;

  logic           start;
  logic           signed_div;
  logic [W-1:0]   opdata1;
  logic [W-1:0]   opdata2;
  logic           annul;
  logic [2*W-1:0] result;
  logic           ready;
  logic           stall_req;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready, stall_req
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready, stall_req
  );
endinterface

// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU), one quotient bit per cycle.
// result = {remainder, quotient}; held while start stays high in END.
module div_seq (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   dvd;      // dividend magnitude, shifted out MSB-first; quotient bits shift in
  logic [W-1:0]   dsr;      // divisor magnitude
  logic [W-1:0]   rem;      // partial remainder
  logic           neg_q;
  logic           neg_r;
  logic           ready_q;
  logic [2*W-1:0] result_q;

  logic [W-1:0]   mag1;
  logic [W-1:0]   mag2;
  logic [W:0]     shifted;
  logic [W:0]     diff;
  logic [W-1:0]   rem_nxt;
  logic [W-1:0]   quo_nxt;
  logic [W-1:0]   rem_fin;
  logic [W-1:0]   quo_fin;

  // Operand magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    mag1 = (bus.signed_div && bus.opdata1[W-1]) ? W'(-bus.opdata1) : bus.opdata1;
    mag2 = (bus.signed_div && bus.opdata2[W-1]) ? W'(-bus.opdata2) : bus.opdata2;
  end

  // One restoring step plus the sign fix-up applied when the last step retires.
  always_comb begin
    shifted = {rem, dvd[W-1]};
    diff    = shifted - {1'b0, dsr};
    rem_nxt = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    quo_nxt = {dvd[W-2:0], ~diff[W]};
    quo_fin = neg_q ? W'(-quo_nxt) : quo_nxt;
    rem_fin = neg_r ? W'(-rem_nxt) : rem_nxt;
  end

  // Control FSM and datapath registers; annul overrides every transition outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (bus.start && !bus.annul) begin
            neg_q <= bus.signed_div & (bus.opdata1[W-1] ^ bus.opdata2[W-1]);
            neg_r <= bus.signed_div & bus.opdata1[W-1];
            dvd   <= mag1;
            dsr   <= mag2;
            rem   <= '0;
            cnt   <= '0;
            state <= (bus.opdata2 == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          cnt <= '0;
          if (bus.annul) begin
            state <= IDLE;
          end else begin
            state    <= END;
            ready_q  <= 1'b1;
            result_q <= '0;
          end
        end
        ON: begin
          if (bus.annul) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            rem <= rem_nxt;
            dvd <= quo_nxt;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(W - 1)) begin
              state    <= END;
              ready_q  <= 1'b1;
              result_q <= {rem_fin, quo_fin};
            end
          end
        end
        END: begin
          if (bus.annul || !bus.start) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          ready_q  <= 1'b0;
          result_q <= '0;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.result    = result_q;
  assign bus.stall_req = bus.start & ~ready_q;
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random divides vs. an arithmetic model.
module tb_div_seq;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  div_if bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit integer division (truncating, remainder takes dividend sign).
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      x = longint'({{32{a[31]}}, a});
      y = longint'({{32{b[31]}}, b});
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called right after inputs were set at a negedge: waits for ready, checks, holds, releases.
  task automatic await_div(input logic [63:0] exp, input int exp_lat, input int hold);
    int lat;
    @(posedge clk); #1;
    lat = 0;
    while (!bus.ready && lat < 40) begin
      chk("stall_busy", 64'(bus.stall_req), 64'd1);
      chk("result_zero_busy", bus.result, 64'd0);
      @(negedge clk);
      bus.opdata1    = $urandom;
      bus.opdata2    = $urandom;
      bus.signed_div = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("result", bus.result, exp);
    chk("stall_done", 64'(bus.stall_req), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.opdata1 = $urandom;
      bus.opdata2 = $urandom;
      @(posedge clk); #1;
      chk("hold_ready", 64'(bus.ready), 64'd1);
      chk("hold_result", bus.result, exp);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("release_ready", 64'(bus.ready), 64'd0);
    chk("release_result", bus.result, 64'd0);
  endtask

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic [63:0] exp);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = s;
    bus.opdata1    = a;
    bus.opdata2    = b;
    await_div(exp, (b == 32'd0) ? 1 : 32, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    n_assert = 0;
    n_fail   = 0;
    clk            = 1'b0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.annul      = 1'b0;
    #1;
    chk("reset_ready", 64'(bus.ready), 64'd0);
    chk("reset_result", bus.result, 64'd0);
    chk("reset_stall", 64'(bus.stall_req), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed values
    run_div(1'b0, 32'd100, 32'd7, 0, {32'd2, 32'd14});
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, {32'h0000_0001, 32'hFFFF_FFFD});
    run_div(1'b0, 32'h1234, 32'd0, 0, 64'd0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, {32'h0, 32'h8000_0000});
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, {32'h0, 32'hFFFF_FFFF});
    run_div(1'b1, 32'h8000_0000, 32'd0, 0, 64'd0);
    run_div(1'b0, 32'h8000_0000, 32'h8000_0000, 0, {32'h0, 32'h1});
    run_div(1'b0, 32'd5, 32'd9, 0, {32'd5, 32'd0});

    // Hold start through END with operands changing
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 3, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

    // Annul mid-ON, then a new divide two edges later
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd7;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      chk("annul_pre_ready", 64'(bus.ready), 64'd0);
    end
    @(negedge clk);
    bus.annul = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    chk("annul_ready", 64'(bus.ready), 64'd0);
    chk("annul_result", bus.result, 64'd0);
    @(negedge clk);
    bus.annul = 1'b0;
    @(posedge clk); #1;
    chk("annul_idle_ready", 64'(bus.ready), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 0, {32'd0, 32'd3});

    // start together with annul in IDLE must not be accepted
    @(negedge clk);
    bus.start = 1'b1; bus.annul = 1'b1; bus.signed_div = 1'b0;
    bus.opdata1 = 32'd20; bus.opdata2 = 32'd6;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("start_annul_ready", 64'(bus.ready), 64'd0);
      chk("start_annul_stall", 64'(bus.stall_req), 64'd1);
    end
    @(negedge clk);
    bus.annul = 1'b0;
    await_div({32'd2, 32'd3}, 32, 0);

    // Async reset mid-ON
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd77; bus.opdata2 = 32'd5;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_on_ready", 64'(bus.ready), 64'd0);
    chk("rst_on_result", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    chk("rst_on_after", 64'(bus.ready), 64'd0);
    run_div(1'b0, 32'd77, 32'd5, 0, {32'd2, 32'd15});

    // Async reset while in END clears ready/result before the next edge
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd50; bus.opdata2 = 32'd4;
    @(posedge clk);
    repeat (32) @(posedge clk);
    #1;
    chk("rst_end_pre_ready", 64'(bus.ready), 64'd1);
    chk("rst_end_pre_result", bus.result, {32'd2, 32'd12});
    #2 rst = 1'b1;
    #1;
    chk("rst_end_ready", 64'(bus.ready), 64'd0);
    chk("rst_end_result", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;

    // Random divides against the model
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (i % 5 == 0) b = {{16{b[15]}}, b[15:0]};
      run_div(s, a, b, i % 3, model(s, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
